// File: rtl/audio_line_pkg.sv
// Shared defaults and types for the audio line FIFO: sample/line geometry and a
// helper computing the packed line width from the frame geometry.
package audio_line_pkg;

  localparam int unsigned SampleWDef    = 16;
  localparam int unsigned ChannelsDef   = 1;
  localparam int unsigned LineFramesDef = 32;
  localparam int unsigned DepthDef      = 4096;

  // Width of one packed output line in bits.
  function automatic int unsigned line_w(input int unsigned sample_w,
                                         input int unsigned channels,
                                         input int unsigned line_frames);
    return sample_w * channels * line_frames;
  endfunction

  localparam int unsigned FrameWDef = SampleWDef * ChannelsDef;
  localparam int unsigned LineWDef  = line_w(SampleWDef, ChannelsDef, LineFramesDef);

  typedef logic [FrameWDef-1:0] frame_t;
  typedef logic [LineWDef-1:0]  line_t;

endpackage

// File: rtl/audio_line_ram.sv
// Simple dual-port line RAM: one synchronous write port, one synchronous read port.
// Read data is registered and only updates when re is high, so a fetched line can
// wait in the read register until the output stage has room for it.
module audio_line_ram
  import audio_line_pkg::*;
#(
  parameter int unsigned DEPTH = DepthDef,
  parameter int unsigned WIDTH = LineWDef,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port; holds its value while re is low.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/audio_line_fifo.sv
// Audio line FIFO: packs multi-channel sample frames into wide lines, stores them in a
// circular line RAM and presents the oldest line through a first-word-fall-through
// registered output stage with valid/ready handshaking.
// Optional feature: define AUDIO_LINE_FLUSH_EN to add the flush input, which commits a
// partially packed line with its unfilled frames zeroed.
module audio_line_fifo
  import audio_line_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = SampleWDef,
  parameter int unsigned CHANNELS    = ChannelsDef,
  parameter int unsigned LINE_FRAMES = LineFramesDef,
  parameter int unsigned DEPTH       = DepthDef,
  localparam int unsigned FW         = SAMPLE_W * CHANNELS,
  localparam int unsigned LINE_W     = line_w(SAMPLE_W, CHANNELS, LINE_FRAMES),
  localparam int unsigned LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef AUDIO_LINE_FLUSH_EN
  input  logic              flush,
`endif
  input  logic [FW-1:0]     in_frame,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [LINE_W-1:0] out_line,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PCW = (LINE_FRAMES > 1) ? $clog2(LINE_FRAMES) : 1;
  localparam logic [PCW-1:0]   LastFrame = PCW'(LINE_FRAMES - 1);
  localparam logic [LVL_W-1:0] LvlFull   = LVL_W'(DEPTH);

  // Packer state.
  logic [PCW-1:0]    pack_cnt_q, pack_cnt_d;
  logic [LINE_W-1:0] pack_buf_q, pack_buf_d;
  logic [LINE_W-1:0] line_next;

  // RAM pointers and occupancy.
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  // Committed lines still sitting in RAM that have not been fetched yet.
  logic [LVL_W-1:0]  fetch_cnt_q, fetch_cnt_d;

  // Output pipeline: RAM read register (rd_pend_q) feeding the output register.
  logic              rd_pend_q;
  logic              out_valid_q;
  logic [LINE_W-1:0] out_line_q;
  logic [LINE_W-1:0] ram_rdata;

  logic              overflow_q;

  logic accept, commit_full, commit_flush, commit;
  logic pop, load, re;

  assign full     = (level_q == LvlFull);
  assign empty    = (level_q == '0);
  // Only the frame that would complete a line needs space; earlier frames go to the packer.
  assign in_ready = ~(full & (pack_cnt_q == LastFrame));

  assign accept      = in_valid & in_ready;
  assign commit_full = accept & (pack_cnt_q == LastFrame);
  assign commit      = commit_full | commit_flush;

  assign pop  = out_valid_q & out_ready;
  // Move the fetched line into the output register when that slot is free or being vacated.
  assign load = rd_pend_q & (~out_valid_q | pop);
  // Fetch the next line when the read register is empty or is being drained this edge.
  assign re   = (fetch_cnt_q != '0) & (~rd_pend_q | load);

`ifdef AUDIO_LINE_FLUSH_EN
  logic flush_pend_q;
  logic flush_req;

  // A flush request persists (while a partial line exists) until it can be committed.
  assign flush_req    = (flush | flush_pend_q) & (pack_cnt_q != '0);
  assign commit_flush = flush_req & ~full;

  // Remember a flush that was held off because the buffer was full.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pend_q <= 1'b0;
    end else begin
      flush_pend_q <= flush_req & ~commit;
    end
  end
`else
  assign commit_flush = 1'b0;
`endif

  // Insert the accepted frame into the line under construction; clear the buffer on commit.
  always_comb begin
    line_next = pack_buf_q;
    for (int k = 0; k < LINE_FRAMES; k++) begin
      if (accept && (pack_cnt_q == PCW'(k))) begin
        line_next[k*FW +: FW] = in_frame;
      end
    end
    pack_cnt_d = pack_cnt_q;
    pack_buf_d = line_next;
    if (commit) begin
      pack_cnt_d = '0;
      pack_buf_d = '0;
    end else if (accept) begin
      pack_cnt_d = pack_cnt_q + 1'b1;
    end
  end

  // Occupancy bookkeeping for committed lines and lines awaiting fetch.
  always_comb begin
    level_d = level_q;
    unique case ({commit, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    fetch_cnt_d = fetch_cnt_q;
    unique case ({commit, re})
      2'b10:   fetch_cnt_d = fetch_cnt_q + 1'b1;
      2'b01:   fetch_cnt_d = fetch_cnt_q - 1'b1;
      default: fetch_cnt_d = fetch_cnt_q;
    endcase
  end

  // Packer, pointers and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pack_cnt_q  <= '0;
      pack_buf_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      fetch_cnt_q <= '0;
    end else begin
      pack_cnt_q  <= pack_cnt_d;
      pack_buf_q  <= pack_buf_d;
      level_q     <= level_d;
      fetch_cnt_q <= fetch_cnt_d;
      if (commit) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (re) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Output stage: read-register occupancy and the registered output line.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_line_q  <= '0;
    end else begin
      if (re) begin
        rd_pend_q <= 1'b1;
      end else if (load) begin
        rd_pend_q <= 1'b0;
      end
      if (load) begin
        out_valid_q <= 1'b1;
        out_line_q  <= ram_rdata;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Sticky overflow: a frame was offered while the FIFO could not take it.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (in_valid & ~in_ready) begin
      overflow_q <= 1'b1;
    end
  end

  audio_line_ram #(
    .DEPTH (DEPTH),
    .WIDTH (LINE_W)
  ) u_ram (
    .clk   (clk),
    .we    (commit),
    .waddr (wr_ptr_q),
    .wdata (line_next),
    .re    (re),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign out_line  = out_line_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign overflow  = overflow_q;

  // Occupancy must stay within capacity.
  a_level_bound: assert property (@(posedge clk) disable iff (rst) level_q <= LvlFull);
  // A stalled output line must not change.
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid_q & ~out_ready) |=> (out_valid_q && $stable(out_line_q)));

endmodule

// File: tb/tb_audio_line_fifo.sv
// Directed bench for audio_line_fifo with a 4-line buffer and default line geometry.
module tb_audio_line_fifo;

  localparam int unsigned Depth = 4;
  localparam int unsigned LW    = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [15:0]   in_frame;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] out_line;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    level;
  logic          full;
  logic          empty;
  logic          overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  audio_line_fifo #(
    .SAMPLE_W    (16),
    .CHANNELS    (1),
    .LINE_FRAMES (32),
    .DEPTH       (Depth)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef AUDIO_LINE_FLUSH_EN
    .flush     (flush),
`endif
    .in_frame  (in_frame),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_line  (out_line),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  // Expected line: frames 0..nfill-1 hold base+k, remaining frames zero.
  function automatic logic [LW-1:0] mk_line(input int base, input int nfill);
    logic [LW-1:0] l;
    l = '0;
    for (int k = 0; k < nfill; k++) l[k*16 +: 16] = 16'(base + k);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frames(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_frame = 16'(base + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_frame = '0;
    tick(); tick();
    rst = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL rst_level got %0d want 0", level); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_empty got %b want 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL rst_full got %b want 0", full); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow got %b want 0", overflow); end
    tests++; if (out_line !== '0) begin fails++; $display("FAIL rst_out_line got %h want 0", out_line); end
  endtask

  task automatic test_pack();
    logic [LW-1:0] exp;
    exp = mk_line(0, 32);
    push_frames(0, 32);
    tests++; if (level !== 3'd1) begin fails++; $display("FAIL pack_level got %0d want 1", level); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL pack_valid_t0 got %b want 0", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL pack_valid_t1 got %b want 0", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL pack_valid_t2 got %b want 1", out_valid); end
    tests++; if (out_line !== exp) begin fails++; $display("FAIL pack_line got %h want %h", out_line, exp); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    tests++; if (empty !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL pack_pop empty=%b valid=%b want 1,0", empty, out_valid);
    end
  endtask

  task automatic test_full();
    logic [LW-1:0] exp;
    out_ready = 1'b0;
    for (int l = 0; l < 4; l++) push_frames(16'h100 * (l + 1), 32);
    tests++; if (full !== 1'b1 || level !== 3'd4) begin
      fails++; $display("FAIL full_flag full=%b level=%0d want 1,4", full, level);
    end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_ready_early got %b want 1", in_ready); end
    push_frames(16'h1000, 31);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_ready_stall got %b want 0", in_ready); end
    in_valid = 1'b1; in_frame = 16'hdead; tick(); in_valid = 1'b0;
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL full_overflow got %b want 1", overflow); end
    tests++; if (level !== 3'd4) begin fails++; $display("FAIL full_level_hold got %0d want 4", level); end
    exp = mk_line(16'h100, 32);
    tests++; if (out_line !== exp) begin fails++; $display("FAIL full_head got %h want %h", out_line, exp); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    tests++; if (in_ready !== 1'b1 || level !== 3'd3) begin
      fails++; $display("FAIL full_after_pop ready=%b level=%0d want 1,3", in_ready, level);
    end
    exp = mk_line(16'h200, 32);
    tests++; if (out_line !== exp) begin fails++; $display("FAIL full_next_head got %h want %h", out_line, exp); end
    push_frames(16'h1000 + 31, 1);
    tests++; if (level !== 3'd4) begin fails++; $display("FAIL full_recommit got %0d want 4", level); end
  endtask

  task automatic test_back_to_back();
    int bases [4];
    logic [LW-1:0] exp;
    bases[0] = 16'h200; bases[1] = 16'h300; bases[2] = 16'h400; bases[3] = 16'h1000;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = mk_line(bases[i], 32);
      tests++; if (out_valid !== 1'b1 || out_line !== exp) begin
        fails++; $display("FAIL b2b_line%0d valid=%b got %h want %h", i, out_valid, out_line, exp);
      end
      tick();
    end
    out_ready = 1'b0;
    tests++; if (empty !== 1'b1 || out_valid !== 1'b0 || level !== 3'd0) begin
      fails++; $display("FAIL b2b_drained empty=%b valid=%b level=%0d want 1,0,0", empty, out_valid,
                        level);
    end
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] exp;
    out_ready = 1'b0;
    push_frames(16'h500, 32);
    push_frames(16'h600, 32);
    push_frames(16'h700, 10);
    tests++; if (level !== 3'd2) begin fails++; $display("FAIL mid_level_pre got %0d want 2", level); end
    rst = 1'b1; in_valid = 1'b1; in_frame = 16'h7777; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tests++; if (level !== 3'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL mid_cleared level=%0d empty=%b valid=%b want 0,1,0", level, empty,
                        out_valid);
    end
    tests++; if (overflow !== 1'b0 || out_line !== '0) begin
      fails++; $display("FAIL mid_regs overflow=%b line=%h want 0,0", overflow, out_line);
    end
    push_frames(16'h2000, 32);
    tick(); tick();
    exp = mk_line(16'h2000, 32);
    tests++; if (out_valid !== 1'b1 || out_line !== exp || level !== 3'd1) begin
      fails++; $display("FAIL mid_line0 valid=%b level=%0d got %h want %h", out_valid, level,
                        out_line, exp);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

`ifdef AUDIO_LINE_FLUSH_EN
  task automatic test_flush();
    logic [LW-1:0] exp;
    push_frames(16'h3000, 5);
    flush = 1'b1; tick(); flush = 1'b0;
    tests++; if (level !== 3'd1) begin fails++; $display("FAIL flush_level got %0d want 1", level); end
    tick(); tick();
    exp = mk_line(16'h3000, 5);
    tests++; if (out_valid !== 1'b1 || out_line !== exp) begin
      fails++; $display("FAIL flush_line valid=%b got %h want %h", out_valid, out_line, exp);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    tick(); tick();
    tests++; if (level !== 3'd0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_noop level=%0d valid=%b want 0,0", level, out_valid);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pack();
    test_full();
    test_back_to_back();
    test_reset_mid();
`ifdef AUDIO_LINE_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
